imem_loader: RTL and testbench

- Writer side of the instruction memory. Receives a byte stream from the host/debug link and assembles big-endian 32-bit instruction words.
- Drives the memory write port with byte addresses 0, 4, 8, and so on. The memory stores each word at index address>>2.
- Holds the CPU pipeline in reset until a complete program image has been written, then releases it.

---
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory writer: packs a big-endian byte stream into 32-bit words,
// writes them at byte addresses 0, 4, 8, ... and holds the CPU until the image is in.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [6:0]        word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [6:0] MAX_WC = 7'(MAX_WORDS);

    state_t              state_q, state_d;
    logic [6:0]          count_q, count_d;
    logic [6:0]          word_idx_q, word_idx_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [DATA_W-9:0]   shift_q, shift_d;
    logic                byte_ready_q, byte_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        byte_ready_d = byte_ready_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count != 7'd0 && word_count <= MAX_WC) begin
                        count_d      = word_count;
                        word_idx_d   = 7'd0;
                        byte_cnt_d   = 2'd0;
                        done_d       = 1'b0;
                        error_d      = 1'b0;
                        busy_d       = 1'b1;
                        cpu_hold_d   = 1'b1;
                        byte_ready_d = 1'b1;
                        state_d      = COLLECT;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (byte_valid && byte_ready_q) begin
                    // MSB-first: earlier bytes migrate toward bit 31
                    shift_d    = {shift_q[DATA_W-17:0], byte_in};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_wdata_d  = {shift_q, byte_in};
                        mem_addr_d   = {word_idx_q[ADDR_W-3:0], 2'b00};
                        mem_we_d     = 1'b1;
                        byte_ready_d = 1'b0;
                        state_d      = WRITE;
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 7'd1;
                if (word_idx_q + 7'd1 == count_q) begin
                    cpu_hold_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = FINISH;
                end else begin
                    byte_cnt_d   = 2'd0;
                    byte_ready_d = 1'b1;
                    state_d      = COLLECT;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            count_q      <= 7'd0;
            word_idx_q   <= 7'd0;
            byte_cnt_q   <= 2'd0;
            shift_q      <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-stream driver, a write scoreboard fed as
// bytes are driven, and status checks after each load.
module tb_imem_loader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [6:0]  word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  dbg_state;

    imem_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [39:0] exp_q[$];
    logic [31:0] img[64];
    logic [39:0] last_wr;
    int          n_pass  = 0;
    int          n_total = 0;
    int          we_count = 0;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Write monitor: every mem_we pulse must match the oldest expected (addr, data)
    always @(negedge clk) begin
        if (reset_n === 1'b1 && mem_we === 1'b1) begin
            we_count++;
            last_wr = {mem_addr, mem_wdata};
            check("ready_during_write", 40'(byte_ready), 40'd0);
            if (exp_q.size() == 0)
                check("write_unexpected", 40'(exp_q.size()), 40'd1);
            else
                check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start(input logic [6:0] wc);
        start      = 1'b1;
        word_count = wc;
        tick();
        start = 1'b0;
    endtask

    // Drive one byte and hold it until accepted; optionally idle afterwards
    task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_ready);
        bit acc;
        acc = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = byte_ready;
            tick();
        end
        check("byte_accept_timeout", 40'(acc), 40'd1);
        byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (chk_ready) check("ready_while_idle_collect", 40'(byte_ready), 40'd1);
            tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit toggle);
        for (int j = 0; j < 4; j++) begin
            logic [7:0] b;
            b = w[31 - 8*j -: 8];
            send_byte(b, (toggle && (j % 2 == 0)) ? 2 : 0, toggle);
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else tick();
        end
        check("done_timeout", 40'(seen), 40'd1);
        check("done_cpu_hold", 40'(cpu_hold), 40'd0);
        check("done_busy", 40'(busy), 40'd0);
        tick();
    endtask

    task automatic run_load(input int n, input bit toggle, input bit mid_start);
        int base;
        base = we_count;
        pulse_start(7'(n));
        check("load_busy", 40'(busy), 40'd1);
        check("load_cpu_hold", 40'(cpu_hold), 40'd1);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({8'(k * 4), img[k]});
            if (mid_start && k == 0) begin
                send_byte(img[0][31:24], 0, 1'b0);
                pulse_start(7'd1);
                check("mid_start_busy", 40'(busy), 40'd1);
                check("mid_start_error", 40'(error), 40'd0);
                for (int j = 1; j < 4; j++) begin
                    logic [7:0] b;
                    b = img[0][31 - 8*j -: 8];
                    send_byte(b, 0, 1'b0);
                end
            end else begin
                send_word(img[k], toggle);
            end
        end
        wait_done();
        check("load_done", 40'(done), 40'd1);
        check("load_error", 40'(error), 40'd0);
        check("load_we_count", 40'(we_count - base), 40'(n));
        check("load_queue_empty", 40'(exp_q.size()), 40'd0);
    endtask

    initial begin
        int base;
        reset_n    = 1'b1;
        start      = 1'b0;
        word_count = 7'd0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;

        do_reset();
        check("rst_outputs", {32'd0, byte_ready, mem_we, busy, done, error, cpu_hold, dbg_state},
              {32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0});
        check("rst_addr_data", {mem_addr, mem_wdata}, 40'd0);

        // Rejected starts
        base = we_count;
        pulse_start(7'd0);
        tick();
        check("wc0_error", 40'(error), 40'd1);
        check("wc0_busy", 40'(busy), 40'd0);
        check("wc0_cpu_hold", 40'(cpu_hold), 40'd1);
        do_reset();
        pulse_start(7'd65);
        tick();
        check("wc65_error", 40'(error), 40'd1);
        check("wc65_busy", 40'(busy), 40'd0);
        check("wc65_cpu_hold", 40'(cpu_hold), 40'd1);
        check("rejected_no_we", 40'(we_count - base), 40'd0);

        // Two-word program, streamed back to back, then with stalls
        img[0] = 32'hE3A00001;
        img[1] = 32'hE2811002;
        run_load(2, 1'b0, 1'b0);
        run_load(2, 1'b1, 1'b0);

        // Largest image: word k holds k
        for (int k = 0; k < 64; k++) img[k] = 32'(k);
        run_load(64, 1'b0, 1'b0);
        check("full_last_write", last_wr, {8'd252, 32'h0000003F});

        // Reset in the middle of word 1; the partial bytes must not leak into the next load
        img[0] = 32'hE3A00001;
        pulse_start(7'd2);
        exp_q.push_back({8'd0, img[0]});
        send_word(img[0], 1'b0);
        send_byte(8'hE2, 0, 1'b0);
        send_byte(8'h81, 0, 1'b0);
        do_reset();
        check("midrst_state", {35'd0, busy, done, error, cpu_hold, mem_we}, {35'd0, 5'b00010});
        check("midrst_queue", 40'(exp_q.size()), 40'd0);
        img[0] = 32'h11223344;
        run_load(1, 1'b0, 1'b0);
        check("midrst_write", last_wr, {8'd0, 32'h11223344});

        // Ignored start during COLLECT, then a reload after done
        img[0] = 32'hCAFEF00D;
        img[1] = 32'h01020304;
        run_load(2, 1'b0, 1'b1);
        check("reload_pre_hold", 40'(cpu_hold), 40'd0);
        img[0] = 32'hA5A55A5A;
        run_load(1, 1'b0, 1'b0);
        check("reload_write", last_wr, {8'd0, 32'hA5A55A5A});

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
